// File: rtl/axi4_mst_bridge.sv
// axi4_mst_bridge: single-outstanding AXI4 master for IFU/LSU-style clients.
// Define AXI_MST_TIMEOUT_EN to add a stalled-slave watchdog.
module axi4_mst_bridge #(
  parameter logic [7:0] MAX_LEN = 8'd7,
  parameter int         TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_awaddr,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [31:0] axi_araddr,
  output logic [7:0]  axi_arlen,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic        axi_rlast
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_AR = 3'd1;
  localparam logic [2:0] RD_R  = 3'd2;
  localparam logic [2:0] WR_AW = 3'd3;
  localparam logic [2:0] WR_B  = 3'd4;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("axi4_mst_bridge: TIMEOUT must be at least 2");
  end

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_last_q, rsp_last_d;

  assign req_ready   = state_q == IDLE;
  assign axi_arvalid = state_q == RD_AR;
  assign axi_rready  = state_q == RD_R;
  assign axi_awvalid = (state_q == WR_AW) & aw_pend_q;
  assign axi_wvalid  = (state_q == WR_AW) & w_pend_q;
  assign axi_bready  = state_q == WR_B;
  assign axi_awaddr  = addr_q;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = arlen_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_last    = rsp_last_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arlen_d     = arlen_q;
    cnt_d       = cnt_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          arlen_d   = (req_len > MAX_LEN) ? MAX_LEN : req_len;
          aw_pend_d = req_wen;
          w_pend_d  = req_wen;
          state_d   = req_wen ? WR_AW : RD_AR;
        end
      end
      RD_AR: begin
        if (axi_arready) begin
          cnt_d   = arlen_q;
          state_d = RD_R;
        end
      end
      RD_R: begin
        if (axi_rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = axi_rdata;
          rsp_last_d  = cnt_q == 8'd0;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = IDLE;
        end
      end
      WR_AW: begin
        // aw and w retire independently; never re-raised once taken
        aw_pend_d = aw_pend_q & ~axi_awready;
        w_pend_d  = w_pend_q & ~axi_wready;
        if (!aw_pend_d && !w_pend_d) state_d = WR_B;
      end
      WR_B: begin
        if (axi_bvalid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      arlen_q     <= 8'd0;
      cnt_q       <= 8'd0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arlen_q     <= arlen_d;
      cnt_q       <= cnt_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  // Burst end is driven by our own count; rlast is only cross-checked.
  always_ff @(posedge clock) begin
    if (!reset && axi_rvalid && axi_rready)
      assert (axi_rlast == (cnt_q == 8'd0))
        else $error("axi4_mst_bridge: rlast disagrees with beat count");
  end

`ifdef AXI_MST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          hs;

  always_comb begin
    hs = (axi_arvalid & axi_arready) | (axi_rvalid & axi_rready)
       | (axi_awvalid & axi_awready) | (axi_wvalid & axi_wready)
       | (axi_bvalid & axi_bready);
    wd_d = (state_q == IDLE || hs) ? '0 : wd_q + TW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
    if (!reset && wd_d == TW'(TIMEOUT))
      $fatal(1, "axi4_mst_bridge: timeout state=%0d addr=%h",
             state_q, addr_q);
  end
`else
  // No watchdog: a silent slave stalls the FSM indefinitely.
`endif
endmodule

// File: tb/tb_axi4_mst_bridge.sv
// tb_axi4_mst_bridge: directed and random checks of axi4_mst_bridge
// against a registered AXI slave and a burst-level reference model.
module tb_axi4_mst_bridge;
  logic        clock, reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  req_len;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_last;
  logic [31:0] rsp_rdata;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic [7:0]  axi_arlen;
  logic        axi_rvalid, axi_rready, axi_rlast;

  int n_assert = 0;
  int n_fail   = 0;

  // slave configuration and observation
  logic        ar_rand, aw_rand, w_after_aw, rgaps;
  logic        rnd_ar, rnd_aw, aw_got, w_got;
  logic [31:0] rd_mem [0:15];
  int          rd_left, rd_ptr, s_left, s_ptr;
  logic        s_awg, s_wg;
  logic [31:0] ar_addr_seen, aw_addr_seen, w_data_seen;
  logic [7:0]  ar_len_seen;
  logic [3:0]  w_strb_seen;

  // per-transaction capture
  logic [31:0] rsp_d [$];
  logic        rsp_l [$];
  logic [3:0]  snap [0:15];
  int          first_k;
  logic        last_rdy, extra_rsp;

  axi4_mst_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign axi_arready = ar_rand ? rnd_ar : 1'b1;
  assign axi_awready = aw_rand ? rnd_aw : 1'b1;
  assign axi_wready  = w_after_aw ? (aw_got & ~w_got) : 1'b1;

  // Registered slave: read beats from rd_mem, B after both halves land.
  always @(posedge clock) begin
    if (reset) begin
      rd_left    <= 0;
      rd_ptr     <= 0;
      axi_rvalid <= 1'b0;
      axi_rlast  <= 1'b0;
      axi_rdata  <= 32'd0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      axi_bvalid <= 1'b0;
      rnd_ar     <= 1'b0;
      rnd_aw     <= 1'b0;
    end else begin
      s_left = rd_left;
      s_ptr  = rd_ptr;
      if (axi_arvalid && axi_arready) begin
        s_left = int'(axi_arlen) + 1;
        s_ptr  = 0;
        ar_addr_seen <= axi_araddr;
        ar_len_seen  <= axi_arlen;
      end
      if (axi_rvalid && axi_rready) begin
        s_left = s_left - 1;
        s_ptr  = s_ptr + 1;
      end
      rd_left <= s_left;
      rd_ptr  <= s_ptr;
      if (s_left > 0 && (!rgaps || $urandom_range(0, 1) == 1)) begin
        axi_rvalid <= 1'b1;
        axi_rdata  <= rd_mem[s_ptr % 16];
        axi_rlast  <= s_left == 1;
      end else begin
        axi_rvalid <= 1'b0;
        axi_rlast  <= 1'b0;
      end
      s_awg = aw_got;
      s_wg  = w_got;
      if (axi_awvalid && axi_awready) begin
        s_awg = 1'b1;
        aw_addr_seen <= axi_awaddr;
      end
      if (axi_wvalid && axi_wready) begin
        s_wg = 1'b1;
        w_data_seen <= axi_wdata;
        w_strb_seen <= axi_wstrb;
      end
      if (axi_bvalid && axi_bready) begin
        s_awg = 1'b0;
        s_wg  = 1'b0;
      end
      aw_got <= s_awg;
      w_got  <= s_wg;
      axi_bvalid <= (s_awg && s_wg && axi_bready && !axi_bvalid)
                  || (axi_bvalid && !axi_bready);
      rnd_ar <= 1'($urandom_range(0, 1));
      rnd_aw <= 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_beats(input logic wen, input logic [7:0] len);
    if (wen) return 1;
    return (len > 8'd7) ? 8 : int'(len) + 1;
  endfunction

  task automatic run_req(input logic wen, input logic [31:0] addr,
                         input logic [7:0] len, input logic [31:0] wd,
                         input logic [3:0] ws);
    int n_exp, got, g, k;
    n_exp = n_beats(wen, len);
    rsp_d.delete();
    rsp_l.delete();
    for (int i = 0; i < 16; i++) snap[i] = 4'd0;
    first_k  = 0;
    last_rdy = 1'b0;
    @(negedge clock);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wd;
    req_wstrb = ws;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clock);
      g++;
    end
    @(posedge clock);
    got = 0;
    k   = 0;
    while (got < n_exp && k < 400) begin
      @(negedge clock);
      k++;
      if (k == 1) req_valid = 1'b0;
      if (k < 16)
        snap[k] = {axi_arvalid, axi_awvalid, axi_wvalid, axi_bready};
      if (rsp_valid) begin
        if (got == 0) first_k = k;
        rsp_d.push_back(rsp_rdata);
        rsp_l.push_back(rsp_last);
        got++;
        if (got == n_exp) last_rdy = req_ready;
      end
    end
    @(negedge clock);
    extra_rsp = rsp_valid;
  endtask

  task automatic check_read(input string tag, input logic [31:0] addr,
                            input logic [7:0] len);
    int n;
    n = n_beats(1'b0, len);
    chk({tag, ".araddr"}, ar_addr_seen, addr);
    chk({tag, ".arlen"}, ar_len_seen, n - 1);
    chk({tag, ".count"}, rsp_d.size(), n);
    for (int i = 0; i < n && i < rsp_d.size(); i++) begin
      chk($sformatf("%s.data%0d", tag, i), rsp_d[i], rd_mem[i]);
      chk($sformatf("%s.last%0d", tag, i), rsp_l[i], i == n - 1);
    end
    chk({tag, ".rdy_at_last"}, last_rdy, 1);
    chk({tag, ".no_extra"}, extra_rsp, 0);
  endtask

  task automatic check_write(input string tag, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] ws);
    chk({tag, ".awaddr"}, aw_addr_seen, addr);
    chk({tag, ".wdata"}, w_data_seen, wd);
    chk({tag, ".wstrb"}, w_strb_seen, ws);
    chk({tag, ".count"}, rsp_d.size(), 1);
    if (rsp_d.size() > 0) begin
      chk({tag, ".rdata0"}, rsp_d[0], 0);
      chk({tag, ".last"}, rsp_l[0], 1);
    end
    chk({tag, ".rdy_at_last"}, last_rdy, 1);
    chk({tag, ".no_extra"}, extra_rsp, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "testbench timeout");
  end

  initial begin
    logic [31:0] a, wd;
    logic [7:0]  ln;
    logic [3:0]  ws;
    logic        wen;
    int          k;
    reset = 1'b1;
    req_valid = 1'b0;
    req_wen = 1'b0;
    req_addr = 32'd0;
    req_len = 8'd0;
    req_wdata = 32'd0;
    req_wstrb = 4'd0;
    ar_rand = 1'b0;
    aw_rand = 1'b0;
    w_after_aw = 1'b0;
    rgaps = 1'b0;
    for (int i = 0; i < 16; i++) rd_mem[i] = 32'd0;
    repeat (3) @(negedge clock);
    chk("rst.req_ready", req_ready, 1);
    chk("rst.valids",
        {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 0);
    chk("rst.rsp", {rsp_valid, rsp_last, rsp_rdata}, 0);
    reset = 1'b0;

    // single-beat read, zero-wait slave
    rd_mem[0] = 32'hDEADBEEF;
    run_req(1'b0, 32'h8000_0000, 8'd0, 32'd0, 4'd0);
    chk("rd0.arvalid_t1", snap[1], 4'b1000);
    chk("rd0.latency", first_k, 3);
    check_read("rd0", 32'h8000_0000, 8'd0);

    // four beats with random rvalid gaps
    rgaps = 1'b1;
    for (int i = 0; i < 4; i++) rd_mem[i] = 32'(i + 1);
    run_req(1'b0, 32'h8000_0100, 8'd3, 32'd0, 4'd0);
    check_read("rd3", 32'h8000_0100, 8'd3);

    // over-long request is clamped to eight beats
    for (int i = 0; i < 16; i++) rd_mem[i] = $urandom;
    run_req(1'b0, 32'h8000_0200, 8'd9, 32'd0, 4'd0);
    check_read("rd9", 32'h8000_0200, 8'd9);

    // wready only after the aw handshake
    w_after_aw = 1'b1;
    run_req(1'b1, 32'ha000_03f8, 8'd0, 32'h41, 4'b0001);
    chk("wr1.t1", snap[1], 4'b0110);
    chk("wr1.t2", snap[2], 4'b0010);
    chk("wr1.t3", snap[3], 4'b0001);
    check_write("wr1", 32'ha000_03f8, 32'h41, 4'b0001);

    // aw and w handshake together
    w_after_aw = 1'b0;
    run_req(1'b1, 32'h8000_1000, 8'd0, 32'h1234_5678, 4'b1111);
    chk("wr2.t1", snap[1], 4'b0110);
    chk("wr2.t2", snap[2], 4'b0001);
    chk("wr2.latency", first_k, 4);
    check_write("wr2", 32'h8000_1000, 32'h1234_5678, 4'b1111);

    // reset after the first of four beats
    rgaps = 1'b0;
    for (int i = 0; i < 4; i++) rd_mem[i] = $urandom;
    @(negedge clock);
    req_valid = 1'b1;
    req_wen = 1'b0;
    req_addr = 32'h8000_0300;
    req_len = 8'd3;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("mid.beat1", {rsp_valid, rsp_rdata}, {1'b1, rd_mem[0]});
    reset = 1'b1;
    @(negedge clock);
    chk("mid.rready", axi_rready, 0);
    chk("mid.rsp_valid", rsp_valid, 0);
    chk("mid.req_ready", req_ready, 1);
    reset = 1'b0;

    // randomized mix with random slave readiness
    ar_rand = 1'b1;
    aw_rand = 1'b1;
    rgaps = 1'b1;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++) rd_mem[i] = $urandom;
      wen = 1'($urandom_range(0, 1));
      a  = $urandom & 32'hffff_fffc;
      ln = 8'($urandom_range(0, 12));
      wd = $urandom;
      ws = 4'($urandom_range(1, 15));
      w_after_aw = 1'($urandom_range(0, 1));
      run_req(wen, a, ln, wd, ws);
      if (wen) check_write($sformatf("rnd%0d.wr", t), a, wd, ws);
      else     check_read($sformatf("rnd%0d.rd", t), a, ln);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
